sram_like_responder: RTL and testbench

SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

---
 rtl/sram_like_responder.sv | 116 +++++++++++
 tb/tb_sram_like_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sram_like_responder.sv
// SRAM-like memory slave: accepts one request per cycle while fewer than DEPTH are
// outstanding, and answers each one in order exactly LATENCY cycles after acceptance.
module sram_like_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int unsigned     Words   = 1 << ADDR_W;
  localparam int unsigned     PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [2:0]      DepthC  = 3'(DEPTH);
  localparam logic [2:0]      LatC    = 3'(LATENCY);
  localparam logic [2:0]      LatM1C  = 3'(LATENCY - 1);

  logic [31:0]       mem_q [Words];

  logic [DEPTH-1:0]  vld_q, vld_d;
  logic              is_rd_q [DEPTH];
  logic [31:0]       data_q  [DEPTH];
  logic [2:0]        age_q   [DEPTH];

  logic [PtrW-1:0]   head_q, tail_q, head_n, tail_n, cand;
  logic [2:0]        cnt_q, cnt_d;
  logic              data_ok_q;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] widx;
  logic [31:0]       rd_word;
  logic              accept, retire, fire;

  // Transfer size and the byte/out-of-range address bits play no part in the data path.
  logic unused_bits;
  assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

  assign widx    = addr[ADDR_W+1:2];
  assign rd_word = mem_q[widx];
  assign addr_ok = resetn && (cnt_q < DepthC);
  assign accept  = req && addr_ok;
  assign retire  = data_ok_q;
  assign head_n  = (head_q == LastPtr) ? '0 : head_q + 1'b1;
  assign tail_n  = (tail_q == LastPtr) ? '0 : tail_q + 1'b1;

  // While the head is being retired, the next entry is the one that may complete next.
  assign cand = retire ? head_n : head_q;
  assign fire = vld_q[cand] && (age_q[cand] == LatM1C);

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !retire) begin
      cnt_d = cnt_q + 3'd1;
    end else if (retire && !accept) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_comb begin
    vld_d = vld_q;
    if (retire) vld_d[head_q] = 1'b0;
    if (accept) vld_d[tail_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      vld_q     <= vld_d;
      cnt_q     <= cnt_d;
      data_ok_q <= fire;
      if (retire) head_q <= head_n;
      if (accept) tail_q <= tail_n;
      if (fire)   rdata_q <= is_rd_q[cand] ? data_q[cand] : 32'h0;
    end
  end

  // Entry payload needs no reset: it is only ever consumed behind a valid bit.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (accept && (tail_q == PtrW'(i))) begin
        is_rd_q[i] <= !wr;
        data_q[i]  <= rd_word;
        age_q[i]   <= '0;
      end else if (vld_q[i] && (age_q[i] != LatC)) begin
        age_q[i] <= age_q[i] + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign data_ok = data_ok_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench: issued requests push expected {rdata, due cycle} into per-DUT queues,
// monitors pop on data_ok. A second instance runs with LATENCY=4 for the back-pressure case.
module tb_sram_like_responder;

  localparam int unsigned Lat  = 2;
  localparam int unsigned Lat4 = 4;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn, req, req4, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok, addr_ok4, data_ok4;
  logic [31:0] rdata, rdata4;

  exp_t        exp_q[$];
  exp_t        exp4_q[$];
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] hold = '0;
  logic [31:0] hold4 = '0;

  bit aok_exp [13] = '{1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1};
  bit dok_exp [13] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1};

  sram_like_responder #(.ADDR_W(10), .LATENCY(Lat), .DEPTH(2)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  sram_like_responder #(.ADDR_W(10), .LATENCY(Lat4), .DEPTH(2)) dut4 (
    .clk(clk), .resetn(resetn), .req(req4), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok4), .data_ok(data_ok4), .rdata(rdata4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      hold <= '0;
    end else if (data_ok) begin
      if (exp_q.size() == 0) begin
        check("unexpected_data_ok", 32'(data_ok), 32'h0);
      end else begin
        check("rdata", rdata, exp_q[0].data);
        check("latency", cyc, exp_q[0].due);
        hold <= exp_q[0].data;
        exp_q.delete(0);
      end
    end else begin
      check("rdata_hold", rdata, hold);
    end
  end

  always @(negedge clk) begin
    if (!resetn) begin
      hold4 <= '0;
    end else if (data_ok4) begin
      if (exp4_q.size() == 0) begin
        check("unexpected_data_ok4", 32'(data_ok4), 32'h0);
      end else begin
        check("rdata4", rdata4, exp4_q[0].data);
        check("latency4", cyc, exp4_q[0].due);
        hold4 <= exp4_q[0].data;
        exp4_q.delete(0);
      end
    end else begin
      check("rdata4_hold", rdata4, hold4);
    end
  end

  // Holds req until accepted (bounded), then returns just after the accepting edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp);
    int n = 0;
    req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s; size = 2'd2;
    while (!addr_ok && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (addr_ok) begin
      exp_q.push_back('{exp, cyc + 1 + Lat});
      @(posedge clk); #1;
    end else begin
      check("accept_timeout", 32'(addr_ok), 32'h1);
      req = 1'b0;
    end
  endtask

  // Idle cycles with write-looking junk on the bus that must be ignored.
  task automatic idle(input int n);
    req = 1'b0; wr = 1'b1; wstrb = 4'hF; wdata = 32'h0BAD_0BAD;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    resetn = 1'b0; req = 1'b1; req4 = 1'b0; wr = 1'b1; size = 2'd2;
    wstrb = 4'hF; addr = 32'h10; wdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr_ok", 32'(addr_ok), 32'h0);
    check("rst_data_ok", 32'(data_ok), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_addr_ok4", 32'(addr_ok4), 32'h0);
    resetn = 1'b1; req = 1'b0;
    #1 check("addr_ok_after_rst", 32'(addr_ok), 32'h1);
    @(posedge clk); #1;

    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'h0);
    idle(3);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF);
    issue(1'b1, 32'h10, 32'h0000_AB00, 4'b0010, 32'h0);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_ABEF);
    issue(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 32'h0);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_ABEF);
    idle(3);

    for (int i = 0; i < 4; i++) issue(1'b1, 32'(4 * i), 32'(i + 1), 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) issue(1'b0, 32'(4 * i), 32'h0, 4'h0, 32'(i + 1));
    idle(4);

    issue(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 32'h0);
    issue(1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFE_F00D);
    idle(5);
    issue(1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFE_F00D);
    issue(1'b0, 32'h1000_0022, 32'h0, 4'h0, 32'hCAFE_F00D);
    issue(1'b1, 32'hFFC, 32'h600D_F00D, 4'hF, 32'h0);
    issue(1'b0, 32'hFFC, 32'h0, 4'h0, 32'h600D_F00D);
    issue(1'b0, 32'h0, 32'h0, 4'h0, 32'h1);
    idle(4);

    // Reset with two reads in flight and a write request held on the bus.
    issue(1'b1, 32'h40, 32'h1111_2222, 4'hF, 32'h0);
    issue(1'b1, 32'h44, 32'h3333_4444, 4'hF, 32'h0);
    idle(4);
    issue(1'b0, 32'h40, 32'h0, 4'h0, 32'h1111_2222);
    issue(1'b0, 32'h44, 32'h0, 4'h0, 32'h3333_4444);
    resetn = 1'b0; req = 1'b1; wr = 1'b1; addr = 32'h40; wdata = 32'hBAD0_BAD0; wstrb = 4'hF;
    exp_q.delete();
    exp4_q.delete();
    #1 check("addr_ok_in_reset", 32'(addr_ok), 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(6);
    issue(1'b0, 32'h40, 32'h0, 4'h0, 32'h1111_2222);
    issue(1'b0, 32'h44, 32'h0, 4'h0, 32'h3333_4444);
    idle(4);

    // LATENCY=4, DEPTH=2 with req held: two accepts, then stall until the first retires.
    wr = 1'b1; addr = 32'h100; wdata = 32'h0000_0005; wstrb = 4'hF; req4 = 1'b1;
    for (int k = 0; k < 13; k++) begin
      if (k == 12) req4 = 1'b0;
      check($sformatf("addr_ok4[%0d]", k), 32'(addr_ok4), 32'(aok_exp[k]));
      check($sformatf("data_ok4[%0d]", k), 32'(data_ok4), 32'(dok_exp[k]));
      if (req4 && addr_ok4) exp4_q.push_back('{32'h0, cyc + 1 + Lat4});
      @(posedge clk); #1;
    end

    n = 0;
    while ((exp_q.size() != 0 || exp4_q.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 32'(exp_q.size() + exp4_q.size()), 32'h0);
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
